// File: rtl/handshake_pkg.sv
`default_nettype none
// ============================================================================
// handshake_pkg : shared sizing helpers and default constant for handshake_* units
// Revision      : 1.0
// ============================================================================
package handshake_pkg;

  localparam logic [11:0] C_DEFAULT_CONST = 12'b111111011001;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  // Index ports keep at least one bit so single-requester builds still elaborate.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// rr_priority_picker : combinational rotating-priority encoder (search starts at ptr)
// Revision           : 1.0
// ============================================================================
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          any,
  output logic [PW-1:0] winner,
  output logic [N-1:0]  grant
);

  logic          w_hi_found;
  logic          w_lo_found;
  logic [PW-1:0] w_hi_idx;
  logic [PW-1:0] w_lo_idx;

  // Lowest requester at or above ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !w_lo_found) begin
        w_lo_found = 1'b1;
        w_lo_idx   = PW'(i);
      end
      if (req[i] && (PW'(i) >= ptr) && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_idx   = PW'(i);
      end
    end
  end

  assign any    = w_lo_found;
  assign winner = w_hi_found ? w_hi_idx : w_lo_idx;

  generate
    for (genvar g = 0; g < N; g++) begin : g_grant
      assign grant[g] = w_lo_found && (winner == PW'(g));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/handshake_constant_rr_arbiter.sv
`default_nettype none
// ============================================================================
// handshake_constant_rr_arbiter : round-robin shared constant source, 1-slot output
// Revision                      : 1.0
// ============================================================================
module handshake_constant_rr_arbiter
  import handshake_pkg::*;
#(
  parameter int                    NUM_REQ     = 4,
  parameter int                    DATA_WIDTH  = 12,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DATA_WIDTH'(C_DEFAULT_CONST),
  localparam int                   IDX_WIDTH   = idx_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_WIDTH-1:0]  outs_idx,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic                 r_full;
  logic [IDX_WIDTH-1:0] r_idx;
  logic [IDX_WIDTH-1:0] r_ptr;

  logic                 w_any;
  logic [IDX_WIDTH-1:0] w_winner;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_load_en;

  rr_priority_picker #(
    .N  (NUM_REQ),
    .PW (IDX_WIDTH)
  ) u_picker (
    .req    (ctrl_valid),
    .ptr    (r_ptr),
    .any    (w_any),
    .winner (w_winner),
    .grant  (w_grant)
  );

  // A drain in the same cycle frees the slot, so loading is allowed while full.
  assign w_load_en  = w_any && (!r_full || outs_ready);
  assign ctrl_ready = w_load_en ? w_grant : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 1'b0;
      r_idx  <= '0;
      r_ptr  <= '0;
    end else if (w_load_en) begin
      r_full <= 1'b1;
      r_idx  <= w_winner;
      r_ptr  <= (w_winner == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : w_winner + 1'b1;
    end else if (r_full && outs_ready) begin
      r_full <= 1'b0;
    end
  end

  assign outs_valid = r_full;
  assign outs       = r_full ? CONST_VALUE : '0;

  generate
    if (NUM_REQ == 1) begin : g_idx_single
      assign outs_idx = '0;
    end else begin : g_idx_multi
      assign outs_idx = r_idx;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_handshake_constant_rr_arbiter.sv
`default_nettype none
// ============================================================================
// tb_handshake_constant_rr_arbiter : scoreboard bench for the constant rr arbiter
// Revision                         : 1.0
// ============================================================================
module tb_handshake_constant_rr_arbiter;

  localparam logic [11:0] C_K = 12'hFD9;

  logic        clk;
  logic        rst;
  logic [3:0]  ctrl_valid;
  logic [3:0]  ctrl_ready;
  logic [11:0] outs;
  logic [1:0]  outs_idx;
  logic        outs_valid;
  logic        outs_ready;

  logic [2:0]  valid3;
  logic [2:0]  ready3;
  logic [11:0] outs3;
  logic [1:0]  outs_idx3;
  logic        outs_valid3;
  logic        outs_ready3;

  int n_tests = 0;
  int n_fail  = 0;
  int n_in    = 0;
  int n_out   = 0;
  int n_discard = 0;
  int sb[$];

  handshake_constant_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (ctrl_valid),
    .ctrl_ready (ctrl_ready),
    .outs       (outs),
    .outs_idx   (outs_idx),
    .outs_valid (outs_valid),
    .outs_ready (outs_ready)
  );

  handshake_constant_rr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(12)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .ctrl_valid (valid3),
    .ctrl_ready (ready3),
    .outs       (outs3),
    .outs_idx   (outs_idx3),
    .outs_valid (outs_valid3),
    .outs_ready (outs_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model + scoreboard for the 4-requester instance, evaluated mid-cycle.
  initial begin : monitor
    int   m_ptr;
    int   m_idx;
    bit   m_full;
    int   m_win;
    int   exp_idx;
    logic [3:0] exp_ready;
    m_ptr = 0; m_idx = 0; m_full = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_full = 0; m_idx = 0; m_ptr = 0;
        n_discard += sb.size();
        sb.delete();
      end else begin
        m_win = -1;
        exp_ready = 4'b0000;
        if (!m_full || outs_ready) begin
          for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_ptr + k) % 4;
            if (m_win < 0 && ctrl_valid[j]) m_win = j;
          end
        end
        if (m_win >= 0) exp_ready[m_win] = 1'b1;
        n_tests++;
        if (ctrl_ready !== exp_ready) begin
          n_fail++;
          $display("FAIL model_ready t=%0t got=%b exp=%b", $time, ctrl_ready, exp_ready);
        end
        n_tests++;
        if (outs_valid !== m_full) begin
          n_fail++;
          $display("FAIL model_valid t=%0t got=%b exp=%b", $time, outs_valid, m_full);
        end
        if (outs_valid && outs_ready) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow t=%0t got=idx%0d exp=no_token", $time, outs_idx);
          end else begin
            exp_idx = sb.pop_front();
            n_out++;
            if (outs_idx !== 2'(exp_idx) || outs !== C_K) begin
              n_fail++;
              $display("FAIL sb_token t=%0t got=idx%0d/%h exp=idx%0d/%h",
                       $time, outs_idx, outs, exp_idx, C_K);
            end
          end
        end
        if (m_win >= 0) begin
          m_full = 1;
          m_idx  = m_win;
          m_ptr  = (m_win + 1) % 4;
          sb.push_back(m_win);
          n_in++;
        end else if (m_full && outs_ready) begin
          m_full = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ctrl_valid = '0; valid3 = '0;
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ctrl_valid = '0; outs_ready = 1'b0;
    #1;
    n_tests++;
    if (outs_valid !== 1'b0 || outs !== 12'h000 || outs_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_init got=%b/%h/%0d exp=0/000/0", outs_valid, outs, outs_idx);
    end
    step(); step();
    rst = 1'b1;
    ctrl_valid = 4'b1111;
    step(); step();
    @(negedge clk);
    n_tests++;
    if (outs_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prefull got=%b exp=1", outs_valid);
    end
    step();
    rst = 1'b0;
    #1;
    n_tests++;
    if (outs_valid !== 1'b0 || outs !== 12'h000 || outs_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_async got=%b/%h/%0d exp=0/000/0", outs_valid, outs, outs_idx);
    end
    step();
    rst = 1'b1; outs_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl_ready !== 4'b0001) begin
      n_fail++;
      $display("FAIL reset_first_grant got=%b exp=0001", ctrl_ready);
    end
    step();
    ctrl_valid = '0;
    step(); step();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    ctrl_valid = 4'b1111; outs_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      exp = 4'b0001 << (k % 4);
      n_tests++;
      if (ctrl_ready !== exp) begin
        n_fail++;
        $display("FAIL rr_ready k=%0d got=%b exp=%b", k, ctrl_ready, exp);
      end
      if (k >= 1) begin
        n_tests++;
        if (outs_valid !== 1'b1 || outs_idx !== 2'((k - 1) % 4) || outs !== C_K) begin
          n_fail++;
          $display("FAIL rr_out k=%0d got=%b/%0d/%h exp=1/%0d/%h",
                   k, outs_valid, outs_idx, outs, (k - 1) % 4, C_K);
        end
      end
      step();
    end
    ctrl_valid = '0;
    step(); step();
  endtask

  task automatic test_skip_wrap();
    do_reset();
    outs_ready = 1'b1;
    ctrl_valid = 4'b0001;
    step();
    ctrl_valid = 4'b1001;
    @(negedge clk);
    n_tests++;
    if (ctrl_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL skip_grant3 got=%b exp=1000", ctrl_ready);
    end
    step();
    @(negedge clk);
    n_tests++;
    if (ctrl_ready !== 4'b0001 || outs_idx !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_grant0 got=%b/idx%0d exp=0001/idx3", ctrl_ready, outs_idx);
    end
    step();
    ctrl_valid = '0;
    @(negedge clk);
    n_tests++;
    if (outs_valid !== 1'b1 || outs_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_out got=%b/idx%0d exp=1/idx0", outs_valid, outs_idx);
    end
    step(); step();
  endtask

  task automatic test_backpressure();
    do_reset();
    ctrl_valid = 4'b1111; outs_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_tests++;
      if (ctrl_ready !== 4'b0000 || outs_valid !== 1'b1 || outs_idx !== 2'd0 || outs !== C_K) begin
        n_fail++;
        $display("FAIL bp_hold k=%0d got=%b/%b/%0d/%h exp=0000/1/0/%h",
                 k, ctrl_ready, outs_valid, outs_idx, outs, C_K);
      end
      step();
    end
    outs_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (ctrl_ready !== 4'b0010 || outs_idx !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_release got=%b/idx%0d exp=0010/idx0", ctrl_ready, outs_idx);
    end
    step();
    ctrl_valid = '0;
    @(negedge clk);
    n_tests++;
    if (outs_valid !== 1'b1 || outs_idx !== 2'd1) begin
      n_fail++;
      $display("FAIL bp_next got=%b/idx%0d exp=1/idx1", outs_valid, outs_idx);
    end
    step(); step();
  endtask

  task automatic test_single_idle();
    do_reset();
    outs_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      ctrl_valid = 4'b0100;
      @(negedge clk);
      n_tests++;
      if (ctrl_ready !== 4'b0100) begin
        n_fail++;
        $display("FAIL single_accept p=%0d got=%b exp=0100", p, ctrl_ready);
      end
      step();
      ctrl_valid = '0;
      @(negedge clk);
      n_tests++;
      if (outs_valid !== 1'b1 || outs_idx !== 2'd2) begin
        n_fail++;
        $display("FAIL single_out p=%0d got=%b/idx%0d exp=1/idx2", p, outs_valid, outs_idx);
      end
      step();
      repeat (p + 1) step();
    end
    ctrl_valid = 4'b1111;
    @(negedge clk);
    n_tests++;
    if (ctrl_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_ptr got=%b exp=1000", ctrl_ready);
    end
    step();
    ctrl_valid = '0;
    step(); step();
  endtask

  task automatic test_n3();
    logic [2:0] exp;
    do_reset();
    valid3 = 3'b111; outs_ready3 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      exp = 3'b001 << (k % 3);
      n_tests++;
      if (ready3 !== exp) begin
        n_fail++;
        $display("FAIL n3_ready k=%0d got=%b exp=%b", k, ready3, exp);
      end
      if (k >= 1) begin
        n_tests++;
        if (outs_valid3 !== 1'b1 || outs_idx3 !== 2'((k - 1) % 3) || outs3 !== C_K) begin
          n_fail++;
          $display("FAIL n3_out k=%0d got=%b/%0d/%h exp=1/%0d/%h",
                   k, outs_valid3, outs_idx3, outs3, (k - 1) % 3, C_K);
        end
      end
      step();
    end
    valid3 = '0;
    step(); step();
  endtask

  task automatic test_scoreboard();
    ctrl_valid = '0; outs_ready = 1'b1;
    step(); step(); step();
    n_tests++;
    if (sb.size() != 0 || n_in != n_out + n_discard || n_in == 0) begin
      n_fail++;
      $display("FAIL sb_balance got=in%0d out%0d discard%0d pending%0d exp=balanced",
               n_in, n_out, n_discard, sb.size());
    end
  endtask

  initial begin
    rst = 1'b0; ctrl_valid = '0; outs_ready = 1'b0;
    valid3 = '0; outs_ready3 = 1'b1;
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_backpressure();
    test_single_idle();
    test_n3();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
